// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Tower-of-Hanoi move sequencer.
package hanoi_pkg;

    typedef logic [1:0] peg_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } gen_state_t;

    localparam peg_t PEG_SRC = 2'd0;
    localparam peg_t PEG_DST = 2'd2;

    function automatic peg_t swap12(input peg_t p);
        peg_t r;
        case (p)
            2'd1:    r = 2'd2;
            2'd2:    r = 2'd1;
            default: r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// Combinational remainder mod 3: since 4 == 1 (mod 3), summing base-4 digits preserves the residue.
module hanoi_mod3 #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] val_i,
    output logic [1:0]   rem_o
);

    localparam int unsigned P  = (W + 1) / 2;
    localparam int unsigned PW = 2 * P;

    logic [PW-1:0] pad;
    logic [7:0]    sum;

    assign pad = PW'(val_i);

    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(P); i++) begin
            sum = sum + 8'(pad[2*i +: 2]);
        end
    end

    assign rem_o = 2'(sum % 8'd3);

endmodule

// File: rtl/hanoi_move_gen.sv
// Closed-form Tower-of-Hanoi move sequencer: emits the 2^S-1 (from, to) moves over a
// valid/ready handshake, derived from the move index alone.
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int unsigned S = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic                   mv_valid_o,
    input  logic                   mv_ready_i,
    output logic [1:0]             mv_fr_o,
    output logic [1:0]             mv_to_o,
    output logic [$clog2(S+1)-1:0] mv_disk_o,
    output logic [S-1:0]           mv_idx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned DW   = $clog2(S + 1);
    localparam bit          Swap = (S % 2) == 0;

    gen_state_t    state_q, state_d;
    logic [S-1:0]  m_q, m_d;
    logic          load;
    logic          hs;
    logic          last;

    peg_t          fr_q, to_q;
    logic [DW-1:0] disk_q;

    logic [S-1:0]  m_dec;
    logic [S-1:0]  and_v;
    logic [S:0]    or_inc;
    peg_t          a_rem, b_rem;
    peg_t          fr_n, to_n;
    logic [DW-1:0] tz;

    assign hs   = mv_valid_o && mv_ready_i;
    assign last = (m_q == {S{1'b1}});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    m_d     = S'(1);
                    load    = 1'b1;
                end
            end
            StRun: begin
                // abort wins over a same-cycle handshake
                if (abort_i) begin
                    state_d = StIdle;
                end else if (hs) begin
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        m_d  = m_q + S'(1);
                        load = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mv_valid_o = (state_q == StRun);
        busy_o     = (state_q == StRun);
        done_o     = (state_q == StDone);
    end

    // Move arithmetic is evaluated on the index about to be loaded so outputs stay registered.
    assign m_dec  = m_d - S'(1);
    assign and_v  = m_d & m_dec;
    assign or_inc = {1'b0, m_d | m_dec} + (S+1)'(1);

    hanoi_mod3 #(.W(S)) u_mod3_a (
        .val_i (and_v),
        .rem_o (a_rem)
    );

    hanoi_mod3 #(.W(S + 1)) u_mod3_b (
        .val_i (or_inc),
        .rem_o (b_rem)
    );

    assign fr_n = Swap ? swap12(a_rem) : a_rem;
    assign to_n = Swap ? swap12(b_rem) : b_rem;

    always_comb begin
        tz = '0;
        for (int i = int'(S) - 1; i >= 0; i--) begin
            if (m_d[i]) begin
                tz = DW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q    <= '0;
            fr_q   <= '0;
            to_q   <= '0;
            disk_q <= '0;
        end else if (load) begin
            m_q    <= m_d;
            fr_q   <= fr_n;
            to_q   <= to_n;
            disk_q <= tz + DW'(1);
        end
    end

    assign mv_fr_o   = fr_q;
    assign mv_to_o   = to_q;
    assign mv_disk_o = disk_q;
    assign mv_idx_o  = m_q;

endmodule

// File: tb/tb_hanoi_move_gen.sv
// Directed bench for hanoi_move_gen with S=3, S=2 and S=1 instances on a shared clock and reset.
module tb_hanoi_move_gen;

    typedef struct {
        logic [3:0] idx;
        logic [1:0] fr;
        logic [1:0] to;
        logic [1:0] disk;
    } vec_t;

    logic clk;
    logic rst_n;

    logic       s3_start, s3_abort, s3_ready, s3_valid, s3_busy, s3_done;
    logic [1:0] s3_fr, s3_to, s3_disk;
    logic [2:0] s3_idx;

    logic       s2_start, s2_abort, s2_ready, s2_valid, s2_busy, s2_done;
    logic [1:0] s2_fr, s2_to, s2_disk;
    logic [1:0] s2_idx;

    logic       s1_start, s1_abort, s1_ready, s1_valid, s1_busy, s1_done;
    logic [1:0] s1_fr, s1_to;
    logic [0:0] s1_disk;
    logic [0:0] s1_idx;

    int checks = 0;
    int errors = 0;

    hanoi_move_gen #(.S(3)) u_s3 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (s3_start),
        .abort_i    (s3_abort),
        .mv_valid_o (s3_valid),
        .mv_ready_i (s3_ready),
        .mv_fr_o    (s3_fr),
        .mv_to_o    (s3_to),
        .mv_disk_o  (s3_disk),
        .mv_idx_o   (s3_idx),
        .busy_o     (s3_busy),
        .done_o     (s3_done)
    );

    hanoi_move_gen #(.S(2)) u_s2 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (s2_start),
        .abort_i    (s2_abort),
        .mv_valid_o (s2_valid),
        .mv_ready_i (s2_ready),
        .mv_fr_o    (s2_fr),
        .mv_to_o    (s2_to),
        .mv_disk_o  (s2_disk),
        .mv_idx_o   (s2_idx),
        .busy_o     (s2_busy),
        .done_o     (s2_done)
    );

    hanoi_move_gen #(.S(1)) u_s1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (s1_start),
        .abort_i    (s1_abort),
        .mv_valid_o (s1_valid),
        .mv_ready_i (s1_ready),
        .mv_fr_o    (s1_fr),
        .mv_to_o    (s1_to),
        .mv_disk_o  (s1_disk),
        .mv_idx_o   (s1_idx),
        .busy_o     (s1_busy),
        .done_o     (s1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 1; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 9;
    endfunction

    vec_t       exp3 [7];
    vec_t       exp2 [3];
    logic [3:0] pegs [3];
    int         acc;
    logic       hold, seen_done, rdy;
    logic [1:0] p_fr, p_to, p_disk;
    logic [2:0] p_idx;

    initial begin
        exp3[0] = '{idx: 4'd1, fr: 2'd0, to: 2'd2, disk: 2'd1};
        exp3[1] = '{idx: 4'd2, fr: 2'd0, to: 2'd1, disk: 2'd2};
        exp3[2] = '{idx: 4'd3, fr: 2'd2, to: 2'd1, disk: 2'd1};
        exp3[3] = '{idx: 4'd4, fr: 2'd0, to: 2'd2, disk: 2'd3};
        exp3[4] = '{idx: 4'd5, fr: 2'd1, to: 2'd0, disk: 2'd1};
        exp3[5] = '{idx: 4'd6, fr: 2'd1, to: 2'd2, disk: 2'd2};
        exp3[6] = '{idx: 4'd7, fr: 2'd0, to: 2'd2, disk: 2'd1};
        exp2[0] = '{idx: 4'd1, fr: 2'd0, to: 2'd1, disk: 2'd1};
        exp2[1] = '{idx: 4'd2, fr: 2'd0, to: 2'd2, disk: 2'd2};
        exp2[2] = '{idx: 4'd3, fr: 2'd1, to: 2'd2, disk: 2'd1};

        rst_n = 1'b0;
        {s3_start, s3_abort, s3_ready} = '0;
        {s2_start, s2_abort, s2_ready} = '0;
        {s1_start, s1_abort, s1_ready} = '0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(s3_valid), 0);
        check("rst_fr",    32'(s3_fr),    0);
        check("rst_to",    32'(s3_to),    0);
        check("rst_disk",  32'(s3_disk),  0);
        check("rst_idx",   32'(s3_idx),   0);
        check("rst_busy",  32'(s3_busy),  0);
        check("rst_done",  32'(s3_done),  0);
        rst_n = 1'b1;
        @(negedge clk);

        // S=3 back-to-back
        s3_ready = 1'b1;
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("s3_valid[%0d]", k), 32'(s3_valid), 1);
            check($sformatf("s3_busy[%0d]", k),  32'(s3_busy),  1);
            check($sformatf("s3_idx[%0d]", k),   32'(s3_idx),   32'(exp3[k].idx));
            check($sformatf("s3_fr[%0d]", k),    32'(s3_fr),    32'(exp3[k].fr));
            check($sformatf("s3_to[%0d]", k),    32'(s3_to),    32'(exp3[k].to));
            check($sformatf("s3_disk[%0d]", k),  32'(s3_disk),  32'(exp3[k].disk));
            check($sformatf("s3_nodone[%0d]", k), 32'(s3_done), 0);
            @(negedge clk);
        end
        check("s3_done",       32'(s3_done),  1);
        check("s3_done_valid", 32'(s3_valid), 0);
        @(negedge clk);
        check("s3_done_pulse", 32'(s3_done), 0);
        check("s3_idle_busy",  32'(s3_busy), 0);

        // S=2 back-to-back
        s2_ready = 1'b1;
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("s2_valid[%0d]", k), 32'(s2_valid), 1);
            check($sformatf("s2_idx[%0d]", k),   32'(s2_idx),   32'(exp2[k].idx));
            check($sformatf("s2_fr[%0d]", k),    32'(s2_fr),    32'(exp2[k].fr));
            check($sformatf("s2_to[%0d]", k),    32'(s2_to),    32'(exp2[k].to));
            check($sformatf("s2_disk[%0d]", k),  32'(s2_disk),  32'(exp2[k].disk));
            @(negedge clk);
        end
        check("s2_done", 32'(s2_done), 1);
        @(negedge clk);
        check("s2_done_pulse", 32'(s2_done), 0);
        check("s2_idle_busy",  32'(s2_busy), 0);

        // S=3 random backpressure with peg model
        pegs[0] = 4'b1110;
        pegs[1] = 4'b0000;
        pegs[2] = 4'b0000;
        acc = 0;
        hold = 1'b0;
        seen_done = 1'b0;
        s3_ready = 1'b0;
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (s3_done) begin
                seen_done = 1'b1;
            end else begin
                if (hold && s3_valid) begin
                    check("rnd_hold_fr",   32'(s3_fr),   32'(p_fr));
                    check("rnd_hold_to",   32'(s3_to),   32'(p_to));
                    check("rnd_hold_disk", 32'(s3_disk), 32'(p_disk));
                    check("rnd_hold_idx",  32'(s3_idx),  32'(p_idx));
                end
                rdy = 1'($urandom_range(0, 1));
                s3_ready = rdy;
                if (s3_valid && rdy) begin
                    if (acc < 7) begin
                        check($sformatf("rnd_idx[%0d]", acc),  32'(s3_idx),  32'(exp3[acc].idx));
                        check($sformatf("rnd_fr[%0d]", acc),   32'(s3_fr),   32'(exp3[acc].fr));
                        check($sformatf("rnd_to[%0d]", acc),   32'(s3_to),   32'(exp3[acc].to));
                        check($sformatf("rnd_disk[%0d]", acc), 32'(s3_disk), 32'(exp3[acc].disk));
                    end
                    if (s3_fr < 2'd3 && s3_to < 2'd3 && s3_disk != 2'd0) begin
                        check("rnd_src_top", 32'(lowest(pegs[s3_fr])), 32'(s3_disk));
                        check("rnd_dst_ok",  32'(lowest(pegs[s3_to]) > int'(s3_disk)), 1);
                        pegs[s3_fr][s3_disk] = 1'b0;
                        pegs[s3_to][s3_disk] = 1'b1;
                    end else begin
                        check("rnd_peg_range", 0, 1);
                    end
                    acc++;
                end
                hold   = s3_valid && !rdy;
                p_fr   = s3_fr;
                p_to   = s3_to;
                p_disk = s3_disk;
                p_idx  = s3_idx;
                @(negedge clk);
            end
        end
        check("rnd_done_seen", 32'(seen_done), 1);
        check("rnd_accepted",  32'(acc),       7);
        check("rnd_peg0",      32'(pegs[0]),   0);
        check("rnd_peg1",      32'(pegs[1]),   0);
        check("rnd_peg2",      32'(pegs[2]),   32'(4'b1110));
        s3_ready = 1'b1;
        @(negedge clk);

        // Abort coincident with the handshake of move 4
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("abt_idx4", 32'(s3_idx), 4);
        s3_abort = 1'b1;
        @(negedge clk);
        s3_abort = 1'b0;
        check("abt_valid", 32'(s3_valid), 0);
        check("abt_busy",  32'(s3_busy),  0);
        check("abt_done",  32'(s3_done),  0);
        @(negedge clk);
        check("abt_done2", 32'(s3_done), 0);
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        check("abt_re_valid", 32'(s3_valid), 1);
        check("abt_re_idx",   32'(s3_idx),   1);
        check("abt_re_fr",    32'(s3_fr),    0);
        check("abt_re_to",    32'(s3_to),    2);
        s3_abort = 1'b1;
        @(negedge clk);
        s3_abort = 1'b0;

        // Asynchronous reset during move 5
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("ars_idx5", 32'(s3_idx), 5);
        s3_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ars_valid", 32'(s3_valid), 0);
        check("ars_fr",    32'(s3_fr),    0);
        check("ars_to",    32'(s3_to),    0);
        check("ars_disk",  32'(s3_disk),  0);
        check("ars_idx",   32'(s3_idx),   0);
        check("ars_busy",  32'(s3_busy),  0);
        check("ars_done",  32'(s3_done),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s3_ready = 1'b1;
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        check("ars_re_valid", 32'(s3_valid), 1);
        check("ars_re_idx",   32'(s3_idx),   1);
        check("ars_re_fr",    32'(s3_fr),    0);
        check("ars_re_to",    32'(s3_to),    2);
        check("ars_re_disk",  32'(s3_disk),  1);
        s3_abort = 1'b1;
        @(negedge clk);
        s3_abort = 1'b0;

        // S=1: single move, start ignored in RUN and DONE
        s1_ready = 1'b0;
        s1_start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("s1_valid[%0d]", k), 32'(s1_valid), 1);
            check($sformatf("s1_idx[%0d]", k),   32'(s1_idx),   1);
            check($sformatf("s1_fr[%0d]", k),    32'(s1_fr),    0);
            check($sformatf("s1_to[%0d]", k),    32'(s1_to),    2);
            check($sformatf("s1_disk[%0d]", k),  32'(s1_disk),  1);
            @(negedge clk);
        end
        s1_ready = 1'b1;
        @(negedge clk);
        check("s1_done",       32'(s1_done),  1);
        check("s1_done_valid", 32'(s1_valid), 0);
        @(negedge clk);
        s1_start = 1'b0;
        check("s1_idle_done",  32'(s1_done),  0);
        check("s1_idle_valid", 32'(s1_valid), 0);
        check("s1_idle_busy",  32'(s1_busy),  0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hanoi_move_gen.md
# hanoi_move_gen

Move sequencer that feeds the peg register file. On `start` it emits the optimal 2^S−1 move sequence that transfers an S-disk tower from peg 0 to peg 2, one (from, to) pair per handshake. The sequence is computed in closed form from a move counter, so the block holds no peg contents. `mv_fr`/`mv_to` connect directly to the register file's `fr`/`to` inputs, and `mv_ready` gates when the register file commits a move.

## Interface
- `S`, default 3: number of disks; legal range 1..15.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a sequence; sampled only in IDLE.
- `abort`  in  1: synchronous abandon of a sequence in progress.
- `mv_valid`  out  1: a move is presented.
- `mv_ready`  in  1: the consumer accepts the move this cycle.
- `mv_fr`  out  2: source peg, 0..2.
- `mv_to`  out  2: destination peg, 0..2, never equal to `mv_fr`.
- `mv_disk`  out  $clog2(S+1): disk moved, where 1 is the smallest disk.
- `mv_idx`  out  S: 1-based index m of the presented move.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse after the final move is accepted.

## Operation
- FSM states: IDLE, RUN, DONE. Enum is `hanoi_pkg::gen_state_t`.
- IDLE → RUN when `start`=1. On the same edge m is loaded with 1 and the outputs for move 1 are registered.
- RUN: handshake = `mv_valid && mv_ready`.
  - Handshake with m < 2^S−1: m increments and the outputs for m+1 are registered.
  - Handshake with m = 2^S−1: go to DONE.
  - No handshake: all `mv_*` outputs hold stable.
- DONE: `done`=1 for exactly one cycle, then IDLE. `mv_valid`=0 in DONE.
- `abort`=1 in RUN or DONE → IDLE on the next edge. `done` is not pulsed. `abort` takes priority over a same-cycle handshake; that move still counts as consumed downstream.
- `start` outside IDLE is ignored. `abort` in IDLE is ignored. `start` and `abort` high together in IDLE: `start` wins.
- Move arithmetic for index m, with m an S-bit value and m−1 computed modulo 2^S:
  - a = (m & (m−1)) mod 3.
  - b = (((m | (m−1)) + 1) mod 3), where the sum is S+1 bits wide with no overflow.
  - For S odd: `mv_fr`=a, `mv_to`=b.
  - For S even: pegs 1 and 2 are swapped in both a and b, so the tower always lands on peg 2.
  - `mv_disk` = count of trailing zeros of m, plus 1.
- All outputs are registered; there is no combinational path from `mv_ready`, `start` or `abort` to any output.

## Timing
- Reset (asynchronous assert, synchronous deassert is the integrator's responsibility): state=IDLE, m=0, `mv_valid`=0, `mv_fr`=0, `mv_to`=0, `mv_disk`=0, `mv_idx`=0, `busy`=0, `done`=0.
- Latency from `start` to first `mv_valid`: 1 cycle.
- With `mv_ready` tied to 1, moves appear back-to-back. The full sequence spans 2^S−1 consecutive `mv_valid` cycles, followed by `done` on the next cycle.
- Back-to-back sequences: `start` can be accepted at the earliest in the cycle after `done`, because DONE returns to IDLE first.
- Reset asserted mid-sequence: all outputs go to their reset values immediately. The downstream register file must be reset alongside.
- Output values while `mv_valid`=0: `mv_fr`/`mv_to`/`mv_disk`/`mv_idx` hold their last values. They are don't-care for consumers.

## Structure
- Package `hanoi_pkg` holds:
  - `peg_t` (logic [1:0]).
  - `gen_state_t`.
  - Constant `PEG_SRC`=0, `PEG_DST`=2.
  - Function `swap12(peg_t)`.
- Sub-module `hanoi_mod3`: parameterised width W, combinational remainder mod 3 by summing 2-bit digit pairs, 2-bit output. Instantiate it twice, for a (W=S) and b (W=S+1).
- Trailing-zero count is a priority-encoder loop inside `hanoi_move_gen`.

## Test plan
- S=3, `mv_ready`=1, pulse `start`:
  - Moves (fr→to, disk): 0→2 d1, 0→1 d2, 2→1 d1, 0→2 d3, 1→0 d1, 1→2 d2, 0→2 d1.
  - `mv_idx` runs 1..7, then `done`=1 for one cycle, then `busy`=0.
- S=2, `mv_ready`=1: moves 0→1 d1, 0→2 d2, 1→2 d1, then `done`.
- S=3, `mv_ready` random 50%: every move holds stable while `mv_ready`=0. The accepted sequence matches the first test exactly and no move is duplicated. A model of the peg register file driven by the accepted moves ends with peg 2 holding all disks, and no larger disk is ever placed on a smaller one.
- S=3: `abort` coincident with the handshake of move 4 → IDLE next cycle, `mv_valid`=0, no `done`. A new `start` restarts at m=1 with move 0→2.
- Async reset:
  - `rst_n` low mid-cycle during move 5 → all outputs zero before the next edge.
  - `rst_n` released, then `start` → sequence restarts at move 1.
- S=1: `start` → single move 0→2 d1, then `done`. `start` asserted during RUN or DONE is ignored.
